// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: register-index width, FSM states,
// the packed bundle of enables/flushes, and the unstalled-cycle control function.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic if_id_fl;
    logic id_ex_fl;
    logic ex_mem_fl;
    logic mem_wb_fl;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = 8'b0000_1111;
  localparam ctrl_t CTRL_FREEZE = 8'b0000_0001;

  // A flush from an older stage kills the younger instruction, so it also cancels its stall.
  function automatic ctrl_t run_ctrl(input logic branch, input logic jump, input logic load_use);
    ctrl_t c;
    c = 8'b1111_0000;
    if (branch) begin
      c.if_id_fl  = 1'b1;
      c.id_ex_fl  = 1'b1;
      c.ex_mem_fl = 1'b1;
    end else if (jump) begin
      c.if_id_fl = 1'b1;
      c.id_ex_fl = 1'b1;
    end else if (load_use) begin
      c.pc_we    = 1'b0;
      c.if_id_we = 1'b0;
      c.id_ex_fl = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: combinational, zero latency, no backpressure of its own.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  // Register 0 is an ordinary register here; no zero-index exemption.
  assign load_use = ex_mem_read & ex_reg_write &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller; outputs are combinational (same-cycle) from state and inputs.
// Memory wait freezes every stage; optional counters exist under PIPELINE_CTRL_STATS_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_jump,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_err
`ifdef PIPELINE_CTRL_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  ctrl_t            ctrl;
  logic             load_use;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_inc;
  logic             timeout;

  hazard_detect u_hazard_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .load_use     (load_use)
  );

  assign wait_inc = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
  assign timeout  = (wait_inc >= (CNT_W + 1)'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (mem_req && !mem_ack) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_ack)             state_nxt = ST_RUN;
                   else if (timeout)        state_nxt = ST_MEM_ERR;
      ST_MEM_ERR:  state_nxt = ST_MEM_ERR;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    ctrl    = CTRL_FREEZE;
    mem_err = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state)
        ST_RUN:      if (!(mem_req && !mem_ack))
                       ctrl = run_ctrl(mem_branch_taken, ex_jump, load_use);
        ST_MEM_WAIT: if (mem_ack)
                       ctrl = run_ctrl(mem_branch_taken, ex_jump, load_use);
        ST_MEM_ERR:  mem_err = 1'b1;
        default:     ctrl = CTRL_FREEZE;
      endcase
    end
  end

  // Zero outside MEM_WAIT so each new wait starts from a clean count; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wait_cnt <= '0;
    else if (state != ST_MEM_WAIT)          wait_cnt <= '0;
    else if (!mem_ack && wait_cnt != CNT_MAX) wait_cnt <= wait_inc[CNT_W-1:0];
  end

  assign pc_write_en     = ctrl.pc_we;
  assign if_id_write_en  = ctrl.if_id_we;
  assign id_ex_write_en  = ctrl.id_ex_we;
  assign ex_mem_write_en = ctrl.ex_mem_we;
  assign if_id_flush     = ctrl.if_id_fl;
  assign id_ex_flush     = ctrl.id_ex_fl;
  assign ex_mem_flush    = ctrl.ex_mem_fl;
  assign mem_wb_flush    = ctrl.mem_wb_fl;

`ifdef PIPELINE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_we && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if ((ctrl.if_id_fl || ctrl.id_ex_fl || ctrl.ex_mem_fl) && flush_events != 16'hFFFF)
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: literal per-vector expectations plus a rule-level model.
module tb_pipeline_ctrl;

  localparam int TO = 15;

  // {mem_err, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
  localparam logic [8:0] NORM = 9'b0_1111_0000;
  localparam logic [8:0] RSTV = 9'b0_0000_1111;
  localparam logic [8:0] FRZ  = 9'b0_0000_0001;
  localparam logic [8:0] ERRV = 9'b1_0000_0001;
  localparam logic [8:0] LU   = 9'b0_0011_0100;
  localparam logic [8:0] JMP  = 9'b0_1111_1100;
  localparam logic [8:0] BR   = 9'b0_1111_1110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0, ex_reg_write = 0;
  logic       ex_jump = 0, mem_branch_taken = 0, mem_req = 0, mem_ack = 0;
  logic       pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
`ifdef PIPELINE_CTRL_STATS_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_jump(ex_jump), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err)
`ifdef PIPELINE_CTRL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         vec_idx = 0;
  logic       active = 1'b0;
  logic       lit_chk = 1'b0;
  logic [8:0] lit_exp = '0;

  // Model state: whether an access is outstanding, how long it has waited, and the sticky error.
  bit m_waiting = 0, m_errored = 0;
  int m_waited = 0, m_stalls = 0, m_flushes = 0;

  function automatic logic [8:0] dut_vec();
    return {mem_err, pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  always @(negedge clk) begin
    logic [8:0] exp;
    logic       hz;
    if (active) begin
      hz = ex_mem_read && ex_reg_write &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      if (rst) begin
        exp = RSTV;
        m_waiting = 0; m_errored = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_errored) begin
        exp = ERRV;
      end else if (m_waiting ? !mem_ack : (mem_req && !mem_ack)) begin
        exp = FRZ;
        if (m_waiting) begin
          m_waited = m_waited + 1;
          if (m_waited == TO) m_errored = 1;
        end else begin
          m_waiting = 1;
          m_waited  = 0;
        end
      end else begin
        m_waiting = 0;
        if (mem_branch_taken) exp = BR;
        else if (ex_jump)     exp = JMP;
        else if (hz)          exp = LU;
        else                  exp = NORM;
      end

      vectors++;
      if (dut_vec() !== exp) begin
        miscompares++;
        $display("FAIL model vec%0d: got %b expected %b", vec_idx, dut_vec(), exp);
      end
      if (lit_chk) begin
        vectors++;
        if (dut_vec() !== lit_exp) begin
          miscompares++;
          $display("FAIL literal vec%0d: got %b expected %b", vec_idx, dut_vec(), lit_exp);
        end
      end
`ifdef PIPELINE_CTRL_STATS_EN
      vectors++;
      if (stall_cycles !== 16'(m_stalls) || flush_events !== 16'(m_flushes)) begin
        miscompares++;
        $display("FAIL stats vec%0d: got %0d/%0d expected %0d/%0d", vec_idx,
                 stall_cycles, flush_events, m_stalls, m_flushes);
      end
`endif
      if (!rst) begin
        if (!exp[7]) m_stalls++;
        if (exp[4] || exp[3] || exp[2]) m_flushes++;
      end
    end
  end

  task automatic drive(input logic r, input logic br, input logic jp,
                       input logic mrd, input logic rw, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic req, input logic ack,
                       input logic [8:0] exp);
    @(posedge clk);
    #1;
    rst = r; mem_branch_taken = br; ex_jump = jp;
    ex_mem_read = mrd; ex_reg_write = rw; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    mem_req = req; mem_ack = ack;
    lit_chk = 1'b1; lit_exp = exp; active = 1'b1;
    vec_idx++;
  endtask

  task automatic mem(input logic req, input logic ack, input logic [8:0] exp);
    drive(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, req, ack, exp);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, RSTV);
    drive(1, 1, 1, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 1, 0, RSTV);
    drive(0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0, 0, NORM);
    // Load-use on rs, then normal flow
    drive(0, 0, 0, 1, 1, 4'd3, 4'd3, 4'd7, 1, 1, 0, 0, LU);
    drive(0, 0, 0, 0, 0, 4'd3, 4'd3, 4'd7, 1, 1, 0, 0, NORM);
    drive(0, 0, 0, 1, 1, 4'd5, 4'd5, 4'd5, 0, 1, 0, 0, LU);
    drive(0, 0, 0, 1, 1, 4'd5, 4'd5, 4'd5, 0, 0, 0, 0, NORM);
    drive(0, 0, 0, 1, 1, 4'd0, 4'd0, 4'd9, 1, 0, 0, 0, LU);
    drive(0, 0, 0, 1, 0, 4'd3, 4'd3, 4'd3, 1, 1, 0, 0, NORM);
    drive(0, 0, 0, 0, 1, 4'd3, 4'd3, 4'd3, 1, 1, 0, 0, NORM);
    drive(0, 0, 1, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, JMP);
    drive(0, 1, 1, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, BR);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0, 0, BR);
    mem(1, 1, NORM);
    // Three-cycle memory wait with hazards ignored, branch applied on the ack cycle
    mem(1, 0, FRZ);
    drive(0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1, 0, FRZ);
    drive(0, 0, 0, 1, 1, 4'd4, 4'd4, 4'd2, 1, 0, 1, 0, FRZ);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1, 1, BR);
    mem(0, 0, NORM);
    // Timeout: 15 wait cycles, then sticky error through a late ack
    mem(1, 0, FRZ);
    for (int i = 0; i < TO; i++) mem(1, 0, FRZ);
    mem(1, 0, ERRV);
    mem(1, 1, ERRV);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0, 1, ERRV);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, RSTV);
    mem(0, 0, NORM);
    // Reset mid-wait, then a fresh wait that ends just short of the limit
    mem(1, 0, FRZ);
    for (int i = 0; i < 3; i++) mem(1, 0, FRZ);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, RSTV);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, RSTV);
    mem(0, 0, NORM);
    mem(1, 0, FRZ);
    for (int i = 0; i < TO - 1; i++) mem(1, 0, FRZ);
    mem(1, 1, NORM);
    mem(0, 0, NORM);
    @(negedge clk);
    #1;
    active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles waiting for mem_ack before flagging an error.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs, id_rt  in  4 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have ports ex_mem_read, ex_reg_write  in  1 each  EX instruction is a load / writes a register.
REQ-007 SHALL have port ex_rd  in  4  destination index of the EX instruction.
REQ-008 SHALL have port ex_jump  in  1  unconditional jump resolved in EX.
REQ-009 SHALL have port mem_branch_taken  in  1  PC-relative branch resolved taken in MEM.
REQ-010 SHALL have ports mem_req  in  1 (MEM stage load/store active) and mem_ack  in  1 (data memory completes the access).
REQ-011 SHALL have ports pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1 each  pipeline register enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  insert bubble into the named register.
REQ-013 SHALL have port mem_err  out  1  sticky memory-timeout flag.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, MEM_ERR; outputs are combinational from state and inputs.
REQ-015 In RUN with no hazard, all write enables SHALL be 1 and all flushes 0.
REQ-016 Load-use hazard SHALL be: ex_mem_read & ex_reg_write & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)); index 0 is not special.
REQ-017 On load-use in RUN: pc_write_en=0, if_id_write_en=0, id_ex_flush=1, for exactly that cycle (one bubble).
REQ-018 On ex_jump in RUN: if_id_flush=1, id_ex_flush=1; PC is written.
REQ-019 On mem_branch_taken in RUN: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; PC is written.
REQ-020 Priority within a cycle: mem_branch_taken > ex_jump > load-use; a lower-priority event is suppressed (no stall) when a flush kills its instruction.
REQ-021 mem_req=1 with mem_ack=0 in RUN SHALL, in that same cycle, deassert all four write enables, assert mem_wb_flush, and transition to MEM_WAIT.
REQ-022 mem_req=1 with mem_ack=1 in RUN SHALL complete with no stall.
REQ-023 In MEM_WAIT, the outputs of REQ-021 SHALL hold; other hazards are ignored until ack.
REQ-024 In MEM_WAIT, mem_ack=1 SHALL return to RUN; that cycle evaluates REQ-015..020 normally (a pending branch/jump/load-use is applied then).
REQ-025 A wait counter SHALL count MEM_WAIT cycles, cleared on entry; on reaching MEM_TIMEOUT without ack, the FSM SHALL enter MEM_ERR.
REQ-026 In MEM_ERR, the pipeline SHALL stay frozen (REQ-021 outputs) and mem_err=1 until reset; mem_ack is ignored.
REQ-027 Counter width SHALL be ceil(log2(MEM_TIMEOUT+1)) bits and SHALL saturate, never wrap.

Reset
REQ-028 rst=1 SHALL asynchronously force state=RUN, wait counter=0, mem_err=0 (and statistics counters=0).
REQ-029 While rst=1, all write enables SHALL be 0 and all four flushes 1; reset during MEM_WAIT discards the access.

Configuration
REQ-030 With macro PIPELINE_CTRL_STATS_EN defined, outputs stall_cycles, flush_events (out, 16 each) SHALL count cycles with pc_write_en=0 and cycles with any flush of if_id/id_ex/ex_mem asserted; both saturate at 16'hFFFF.
REQ-031 Without PIPELINE_CTRL_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-032 FSM state encodings and the register-index width (4) SHALL be defined in lapido_defs.v.
REQ-033 Load-use comparison SHALL be a sub-module hazard_detect (purely combinational); FSM, timeout and statistics live in pipeline_ctrl.

Verification
REQ-034 Load r3 in EX (ex_rd=3), ID reads rs=3 -> one cycle pc_write_en=0, id_ex_flush=1, then normal flow.
REQ-035 ex_jump=1 and a load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_write_en=1, no stall.
REQ-036 mem_branch_taken=1 -> if_id_flush=id_ex_flush=ex_mem_flush=1 for one cycle.
REQ-037 mem_req=1, mem_ack after 3 cycles -> enables 0 and mem_wb_flush=1 for 3 cycles, RUN on ack cycle.
REQ-038 mem_req=1, no ack, MEM_TIMEOUT=15 -> mem_err=1 after 15 MEM_WAIT cycles, stays set through a late ack; rst clears it.
REQ-039 rst asserted mid-MEM_WAIT -> immediate RUN, counters 0, all flushes 1 while rst high.
